// File: rtl/step_gen_pkg.sv
// Shared types and constants for the step pulse generator.
//   state_e      : IDLE / HIGH / LOW burst states
//   COUNT_W      : width of burst length and sent counter
//   PERIOD_W     : width of period and per-state ms counter
//   DEF_TICK_DIV : default clk100MHz cycles per 1 ms tick
//   DEF_PULSE_MS : default X high time in ms
package step_gen_pkg;

  localparam int unsigned COUNT_W      = 20;
  localparam int unsigned PERIOD_W     = 12;
  localparam int unsigned DEF_TICK_DIV = 100000;
  localparam int unsigned DEF_PULSE_MS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Increment that sticks at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Control/status bundle of the step pulse generator.
//   start, stop           : single-cycle burst request / abort
//   period_ms, burst_len  : burst configuration, latched on accepted start
//   X, busy, done         : step output, burst active, end-of-burst pulse
//   sent_count            : steps emitted in current/last burst
interface step_pulse_gen_if;
  import step_gen_pkg::*;

  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period_ms;
  logic [COUNT_W-1:0]  burst_len;
  logic                X;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  sent_count;

  modport master (
    output start, stop, period_ms, burst_len,
    input  X, busy, done, sent_count
  );

  modport slave (
    input  start, stop, period_ms, burst_len,
    output X, busy, done, sent_count
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks.
//   clk100MHz, reset_n : clock, async active-low reset
//   i_clr              : synchronous restart of the prescaler
//   o_tick_c           : combinational tick, high on the last cycle of each ms
module ms_tick_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk100MHz,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre;

  // Free-running divider, restarted by i_clr.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (i_clr || (r_pre == PRE_LAST)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign o_tick_c = (r_pre == PRE_LAST) && !i_clr;

endmodule

// File: rtl/step_pulse_gen.sv
// Step pulse burst generator.
//   clk100MHz, reset_n : clock, async active-low reset
//   bus (slave)        : start/stop/period_ms/burst_len in,
//                        X/busy/done/sent_count out (all registered)
// X is high PULSE_MS ms and repeats every P ms, P = latched period_ms
// clamped to at least PULSE_MS+1. burst_len 0 runs until stop.
module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned PULSE_MS = DEF_PULSE_MS
) (
  input  logic              clk100MHz,
  input  logic              reset_n,
  step_pulse_gen_if.slave   bus
);

  localparam logic [PERIOD_W-1:0] HIGH_MS = PERIOD_W'(PULSE_MS);

  state_e              r_state;
  logic                r_x;
  logic                r_busy;
  logic                r_done;
  logic [COUNT_W-1:0]  r_sent;
  logic [COUNT_W-1:0]  r_burst;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_ms_cnt;

  logic                w_tick;
  logic                w_accept;
  logic [PERIOD_W-1:0] w_low_ms;

  assign w_accept = (r_state == IDLE) && bus.start;

  // Short periods clamp to PULSE_MS+1, which leaves exactly 1 ms of LOW.
  assign w_low_ms = (r_period <= HIGH_MS) ? PERIOD_W'(1) : (r_period - HIGH_MS);

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk100MHz (clk100MHz),
    .reset_n   (reset_n),
    .i_clr     (w_accept),
    .o_tick_c  (w_tick)
  );

  // Burst FSM; outputs change together with the state.
  always_ff @(posedge clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_x      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sent   <= '0;
      r_burst  <= '0;
      r_period <= '0;
      r_ms_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_period <= bus.period_ms;
            r_burst  <= bus.burst_len;
            r_sent   <= COUNT_W'(1);   // first step rises on this edge
            r_ms_cnt <= '0;
            r_state  <= HIGH;
            r_x      <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        HIGH: begin
          if (bus.stop) begin
            r_state  <= IDLE;
            r_x      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_ms_cnt <= '0;
          end else if (w_tick) begin
            if (r_ms_cnt == HIGH_MS - PERIOD_W'(1)) begin
              r_state  <= LOW;
              r_x      <= 1'b0;
              r_ms_cnt <= '0;
            end else begin
              r_ms_cnt <= r_ms_cnt + PERIOD_W'(1);
            end
          end
        end
        LOW: begin
          if (bus.stop) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_ms_cnt <= '0;
          end else if (w_tick) begin
            if (r_ms_cnt == w_low_ms - PERIOD_W'(1)) begin
              r_ms_cnt <= '0;
              if ((r_burst != '0) && (r_sent == r_burst)) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= HIGH;
                r_x     <= 1'b1;
                r_sent  <= sat_inc(r_sent);
              end
            end else begin
              r_ms_cnt <= r_ms_cnt + PERIOD_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_x     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.X          = r_x;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sent_count = r_sent;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen with TICK_DIV=4, PULSE_MS=2.
// Expected outputs come from an arithmetic model of the pulse train:
// rises every P*TICK_DIV cycles starting at cycle 1, high for
// PULSE_MS*TICK_DIV cycles, burst ending at cycle 1 + burst_len*P*TICK_DIV.
module tb_step_pulse_gen;

  localparam int TD = 4;
  localparam int PM = 2;

  typedef struct {
    bit x;
    bit busy;
    bit done;
    int sent;
  } exp_t;

  logic clk100MHz = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  step_pulse_gen_if bus_if ();

  step_pulse_gen #(
    .TICK_DIV (TD),
    .PULSE_MS (PM)
  ) dut (
    .clk100MHz (clk100MHz),
    .reset_n   (reset_n),
    .bus       (bus_if)
  );

  always #5 clk100MHz = ~clk100MHz;

  // Uninterrupted burst behaviour at cycle n (n=1 is the first cycle after start).
  function automatic exp_t natural_at(input int n, input int p, input int blen);
    exp_t e;
    int   tp;
    int   ending;
    tp     = p * TD;
    ending = 1 + blen * tp;
    if (blen != 0 && n >= ending) begin
      e.x    = 1'b0;
      e.busy = 1'b0;
      e.done = (n == ending);
      e.sent = blen;
    end else begin
      e.x    = (((n - 1) % tp) < PM * TD);
      e.busy = 1'b1;
      e.done = 1'b0;
      e.sent = (n - 1) / tp + 1;
    end
    return e;
  endfunction

  // Burst behaviour including an optional stop sampled at the end of cycle stop_at.
  function automatic exp_t model_at(input int n, input int p, input int blen, input int stop_at);
    exp_t e;
    int   ending;
    ending = (blen != 0) ? 1 + blen * p * TD : 32'h7fff_ffff;
    if (stop_at > 0 && stop_at < ending && n > stop_at) begin
      e      = natural_at(stop_at, p, blen);
      e.x    = 1'b0;
      e.busy = 1'b0;
      e.done = (n == stop_at + 1);
    end else begin
      e = natural_at(n, p, blen);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int n, input exp_t e);
    chk({tag, ".X"},    n, 32'(bus_if.X),          32'(e.x));
    chk({tag, ".busy"}, n, 32'(bus_if.busy),       32'(e.busy));
    chk({tag, ".done"}, n, 32'(bus_if.done),       32'(e.done));
    chk({tag, ".sent"}, n, 32'(bus_if.sent_count), 32'(e.sent));
  endtask

  // Start a burst and check every cycle against the model.
  // poke_at: cycle at which start plus period_ms=9 is driven while busy.
  task automatic run_burst(input string tag, input int p_in, input int blen, input int stop_at,
                           input bit stop_with_start, input bit noise, input int poke_at,
                           input int ncyc);
    int   p;
    int   ending;
    exp_t e;
    p      = (p_in <= PM) ? PM + 1 : p_in;
    ending = (blen != 0) ? 1 + blen * p * TD : 32'h7fff_ffff;
    bus_if.period_ms = 12'(p_in);
    bus_if.burst_len = 20'(blen);
    bus_if.start     = 1'b1;
    bus_if.stop      = stop_with_start;
    @(posedge clk100MHz); #1;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      e = model_at(n, p, blen, stop_at);
      chk_all(tag, n, e);
      bus_if.stop  = (n == stop_at);
      bus_if.start = 1'b0;
      if (noise && n < ending && (stop_at == 0 || n <= stop_at)) begin
        bus_if.period_ms = 12'($urandom_range(0, 15));
        bus_if.burst_len = 20'($urandom_range(0, 6));
        bus_if.start     = ($urandom_range(0, 3) == 0);
      end
      if (n == poke_at) begin
        bus_if.start     = 1'b1;
        bus_if.period_ms = 12'd9;
        bus_if.burst_len = 20'd1;
      end
      @(posedge clk100MHz); #1;
    end
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
  endtask

  initial begin
    exp_t idle0;
    int   rp;
    int   rb;
    int   rs;
    int   rend;
    int   rn;

    idle0.x = 1'b0; idle0.busy = 1'b0; idle0.done = 1'b0; idle0.sent = 0;

    reset_n          = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.stop      = 1'b0;
    bus_if.period_ms = '0;
    bus_if.burst_len = '0;
    repeat (3) @(posedge clk100MHz);
    #1;
    chk_all("reset", 0, idle0);
    reset_n = 1'b1;
    @(posedge clk100MHz); #1;

    // stop while idle does nothing
    bus_if.stop = 1'b1;
    @(posedge clk100MHz); #1;
    bus_if.stop = 1'b0;
    chk_all("idle_stop", 0, idle0);

    run_burst("burst",  5, 3,  0, 1'b0, 1'b0,  0, 66);
    run_burst("ignore", 5, 2,  0, 1'b0, 1'b0, 10, 45);
    run_burst("clamp",  1, 2,  0, 1'b0, 1'b0,  0, 30);
    run_burst("stop",   4, 0, 20, 1'b0, 1'b0,  0, 28);

    // stop after the burst is over: sent_count held at 2
    bus_if.stop = 1'b1;
    @(posedge clk100MHz); #1;
    bus_if.stop = 1'b0;
    @(posedge clk100MHz); #1;
    chk("held.busy", 0, 32'(bus_if.busy),       32'd0);
    chk("held.done", 0, 32'(bus_if.done),       32'd0);
    chk("held.sent", 0, 32'(bus_if.sent_count), 32'd2);

    run_burst("simul",  4, 1,  0, 1'b1, 1'b0,  0, 20);

    for (int it = 0; it < 12; it++) begin
      rp   = int'($urandom_range(0, 7));
      rb   = int'($urandom_range(0, 4));
      rs   = (rb == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 80)) : 0;
      rend = (rb != 0) ? 1 + rb * ((rp <= PM) ? PM + 1 : rp) * TD : 32'h7fff_ffff;
      rn   = ((rs > 0 && rs < rend) ? rs : rend) + 4;
      if (rs >= rn) rn = rs + 3;
      run_burst("rand", rp, rb, rs, 1'b0, 1'b1, 0, rn);
      repeat (int'($urandom_range(0, 5))) @(posedge clk100MHz);
      #1;
    end

    // asynchronous reset in the middle of a HIGH pulse
    bus_if.period_ms = 12'd5;
    bus_if.burst_len = 20'd0;
    bus_if.start     = 1'b1;
    @(posedge clk100MHz); #1;
    bus_if.start = 1'b0;
    @(posedge clk100MHz); #1;
    @(posedge clk100MHz); #3;
    chk("pre_rst.X",    3, 32'(bus_if.X),          32'd1);
    chk("pre_rst.busy", 3, 32'(bus_if.busy),       32'd1);
    chk("pre_rst.sent", 3, 32'(bus_if.sent_count), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 3, idle0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk100MHz); #1;
      chk_all("in_rst", k, idle0);
    end
    reset_n = 1'b1;
    @(posedge clk100MHz); #1;
    chk_all("post_rst", 0, idle0);

    run_burst("after_rst", 3, 1, 0, 1'b0, 1'b0, 0, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
